ise_sorter: RTL
===============

# ise_sorter

Parametrised image classify-and-sort engine, the next generation of the fixed 32-image / 128×128 ISE core. It streams RGB pixels for a batch of `IMG_NUM` images and classifies each image by its dominant colour. It keeps a sorted table using one-entry-per-cycle insertion and, after the last image, emits the image indices in sorted order. Image count, pixel count, channel width and metric sort direction are all parametrised.

## Interface
- `IMG_NUM`, 32: images per batch (≥2).
- `PIX_NUM`, 16384: pixels per image (≥2).
- `CH_W`, 8: bits per colour channel.
- `METRIC_DESC`, 0: 0 sorts metric ascending within a colour group, 1 sorts it descending.
- Derived: `IDX_W`=clog2(IMG_NUM), `SUM_W`=CH_W+clog2(PIX_NUM), `CNT_W`=clog2(PIX_NUM+1).
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `in_valid`  in  1  pixel present.
- `image_in_index`  in  IDX_W  image tag of the current pixel.
- `pixel_in`  in  3*CH_W  {R,G,B}, with R in the MSBs.
- `busy`  out  1  registered; while high, input is ignored.
- `out_valid`  out  1  result beat.
- `color_index`  out  2  0=R, 1=G, 2=B; 3 is never driven.
- `image_out_index`  out  IDX_W  sorted image tag.

## Operation
- **Pixel acceptance:** a pixel is accepted on an edge where `in_valid` is 1 and `busy` is 0.
- **Pixel colour:** the pixel's dominant channel is its max component. Ties resolve R>G>B.
- **Per-image counters:** three dominant-pixel counters (CNT_W bits) and three channel sums (SUM_W bits, no overflow possible).
- **Image tag:** the tag is the `image_in_index` of the first accepted pixel of the image. Tags on later pixels are ignored.
- **Image class:** the channel with the highest dominant-pixel count. Ties resolve R>G>B.
- **Metric:** the class channel's sum over all pixels of the image.
- **Sort key:** {class, metric'}, where metric' is the metric when METRIC_DESC=0 and ~metric when METRIC_DESC=1. The table is ascending by key and stable (equal keys keep arrival order).
- **FSM states:**
  - IDLE/ACCUM: accumulate pixels. Acceptance of pixel PIX_NUM-1 goes to FINAL.
  - FINAL (1 cycle): latch tag, class and metric into the new entry. Clear the accumulators. Set pointer p=n, the number of stored entries. Go to INSERT.
  - INSERT: each cycle, if p>0 and key[p-1] > newkey (strictly greater), shift table[p]←table[p-1] and decrement p. Otherwise write table[p]←new and increment n. Then go to OUTPUT if n=IMG_NUM, else to ACCUM.
  - OUTPUT: emit one entry per cycle, table[0] first, for IMG_NUM consecutive cycles. Then clear n and go to ACCUM.
- **Busy:** `busy`=1 in FINAL, INSERT and OUTPUT, and 0 in ACCUM.
- **Reset values:** `busy`=0, `out_valid`=0, `color_index`=0, `image_out_index`=0. The table is empty (n=0) and the accumulators are 0.

## Timing
- `busy` rises on the same edge that accepts the last pixel of an image, so it is visible the following cycle. That last pixel is counted.
- Busy window per image = 1 (FINAL) + s shifts + 1 write, where s ≤ n. `busy` falls on the edge that performs the write; for a non-final image, the next pixel can be accepted in the following cycle.
- For the final image, `busy` stays high without a gap. `out_valid` asserts the cycle after the last insert write and holds for exactly IMG_NUM cycles. `busy` falls on the edge that ends the last beat.
- Outputs are registered. `color_index` and `image_out_index` are 0 whenever `out_valid`=0.
- Reset mid-pixel, mid-insert or mid-output: the next cycle all outputs are 0 and the batch is discarded.
- `in_valid` may drop between pixels of the same image; the accumulators hold their values.

## Structure
- Package `ise_pkg` holds:
  - colour encodings `CLR_R`/`CLR_G`/`CLR_B`;
  - the FSM state enum;
  - the `clog2` function used for derived widths.
- Sub-module `ise_accum`: per-pixel dominant-channel selection, the three counters, the three sums, and the class/metric outputs, with a clear input.
- The top level holds the table (IMG_NUM × {class, metric, tag}), the insert pointer and the FSM.

## Test plan
Parameters: IMG_NUM=4, PIX_NUM=4, CH_W=8 unless stated.
- **Single image class and metric:** tag 2 sends four `FF0000` pixels, followed by filler images. The image has class R and metric 0x3FC, and its entry appears at the correct sorted position.
- **Tie rules:** tag 0 sends `808000`, `808000`, `00FF00`, `0000FF`. The pixels classify as R,R,G,B and the image class is R. A second image with pixels G,G,B,B (tag 1) classifies as G.
- **Batch ordering:** tags 0..3 with (class, metric) = (B,10), (R,40), (G,5), (R,20). The output sequence is tags 3,1,2,0 with colours 0,0,1,2 across 4 consecutive `out_valid` cycles.
- **Stability and descending mode:** tags 0 and 1 have identical R metric. The output order is 0 before 1. The same batch with METRIC_DESC=1 reverses metric order within the R group while keeping 0 before 1 for equal metrics.
- **Busy length:** with 3 entries already stored, a new smallest key arrives. `busy` is high for 5 cycles and input offered during those cycles is ignored.
- **Reset recovery:** `reset` pulses during INSERT of image 3. `out_valid` never asserts for that batch. A fresh 4-image batch then sorts correctly.

Source files
------------

// File: rtl/ise_pkg.sv
// ise_pkg: shared colour encodings, FSM states and width helper for the ise_sorter
package ise_pkg;
    localparam logic [1:0] CLR_R = 2'd0;
    localparam logic [1:0] CLR_G = 2'd1;
    localparam logic [1:0] CLR_B = 2'd2;

    typedef enum logic [1:0] {S_ACCUM, S_FINAL, S_INSERT, S_OUTPUT} state_e;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/ise_accum.sv
// ise_accum: per-image dominant-colour counters and channel sums with class/metric result
module ise_accum
    import ise_pkg::*;
#(
    parameter int PIX_NUM = 16384,
    parameter int CH_W = 8,
    localparam int SUM_W = CH_W + clog2(PIX_NUM),
    localparam int CNT_W = clog2(PIX_NUM + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [3*CH_W-1:0] pixel_i,
    output logic              first_o,
    output logic              last_o,
    output logic [1:0]        cls_o,
    output logic [SUM_W-1:0]  met_o
);
    logic [CH_W-1:0] r, g, b;
    logic [1:0] dom;
    logic [CNT_W-1:0] pix_q;
    logic [CNT_W-1:0] cnt_q [3];
    logic [SUM_W-1:0] sum_q [3];

    assign {r, g, b} = pixel_i;
    assign dom = (r >= g && r >= b) ? CLR_R : (g >= b) ? CLR_G : CLR_B;
    assign first_o = pix_q == '0;
    assign last_o = en_i && pix_q == CNT_W'(PIX_NUM - 1);
    assign cls_o = (cnt_q[0] >= cnt_q[1] && cnt_q[0] >= cnt_q[2]) ? CLR_R : (cnt_q[1] >= cnt_q[2]) ? CLR_G : CLR_B;
    assign met_o = sum_q[cls_o];

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            pix_q <= '0;
            for (int c = 0; c < 3; c++) begin
                cnt_q[c] <= '0;
                sum_q[c] <= '0;
            end
        end else if (en_i) begin
            pix_q <= pix_q + 1'b1;
            for (int c = 0; c < 3; c++) begin
                cnt_q[c] <= cnt_q[c] + CNT_W'(dom == 2'(c));
                sum_q[c] <= sum_q[c] + SUM_W'(pixel_i[(2-c)*CH_W +: CH_W]);
            end
        end
    end
endmodule

// File: rtl/ise_sorter.sv
// ise_sorter: classifies each image by dominant colour and emits image tags in sorted order
module ise_sorter
    import ise_pkg::*;
#(
    parameter int IMG_NUM = 32,
    parameter int PIX_NUM = 16384,
    parameter int CH_W = 8,
    parameter bit METRIC_DESC = 1'b0,
    localparam int IDX_W = clog2(IMG_NUM),
    localparam int SUM_W = CH_W + clog2(PIX_NUM)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [IDX_W-1:0]  image_in_index,
    input  logic [3*CH_W-1:0] pixel_in,
    output logic              busy,
    output logic              out_valid,
    output logic [1:0]        color_index,
    output logic [IDX_W-1:0]  image_out_index
);
    state_e state_q, state_d;
    logic [IDX_W:0] n_q, n_d;
    logic [IDX_W-1:0] p_q, p_d, o_q, o_d, pm1, on1;
    logic [IDX_W-1:0] tag_q, new_tag_q;
    logic [1:0] new_cls_q;
    logic [SUM_W-1:0] new_met_q;
    logic [1:0] tbl_cls [IMG_NUM];
    logic [SUM_W-1:0] tbl_met [IMG_NUM];
    logic [IDX_W-1:0] tbl_tag [IMG_NUM];
    logic busy_q, ov_q, ov_d;
    logic [1:0] oc_q, oc_d;
    logic [IDX_W-1:0] oi_q, oi_d;
    logic acc, first, last, fin, shift, wr;
    logic [1:0] cls;
    logic [SUM_W-1:0] met;

    // Descending mode inverts the metric so the table itself is always ascending
    function automatic logic [SUM_W+1:0] key(input logic [1:0] c, input logic [SUM_W-1:0] m);
        return {c, METRIC_DESC ? ~m : m};
    endfunction

    assign acc = in_valid && !busy_q;
    assign pm1 = p_q - IDX_W'(1);
    assign on1 = o_q + IDX_W'(1);

    ise_accum #(.PIX_NUM(PIX_NUM), .CH_W(CH_W)) u_accum (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (fin),
        .en_i   (acc),
        .pixel_i(pixel_in),
        .first_o(first),
        .last_o (last),
        .cls_o  (cls),
        .met_o  (met)
    );

    always_comb begin
        state_d = state_q;
        n_d = n_q;
        p_d = p_q;
        o_d = o_q;
        fin = 1'b0;
        shift = 1'b0;
        wr = 1'b0;
        ov_d = 1'b0;
        oc_d = 2'd0;
        oi_d = '0;
        case (state_q)
            S_ACCUM: state_d = last ? S_FINAL : S_ACCUM;
            S_FINAL: begin
                fin = 1'b1;
                p_d = n_q[IDX_W-1:0];
                state_d = S_INSERT;
            end
            S_INSERT: begin
                if (p_q != '0 && key(tbl_cls[pm1], tbl_met[pm1]) > key(new_cls_q, new_met_q)) begin
                    shift = 1'b1;
                    p_d = pm1;
                end else begin
                    wr = 1'b1;
                    n_d = n_q + 1'b1;
                    state_d = S_ACCUM;
                    if (n_d == (IDX_W+1)'(IMG_NUM)) begin
                        // First beat bypasses the table in case the new entry lands at slot 0
                        state_d = S_OUTPUT;
                        o_d = '0;
                        ov_d = 1'b1;
                        oc_d = (p_q == '0) ? new_cls_q : tbl_cls[0];
                        oi_d = (p_q == '0) ? new_tag_q : tbl_tag[0];
                    end
                end
            end
            S_OUTPUT: begin
                if (o_q == IDX_W'(IMG_NUM - 1)) begin
                    n_d = '0;
                    state_d = S_ACCUM;
                end else begin
                    o_d = on1;
                    ov_d = 1'b1;
                    oc_d = tbl_cls[on1];
                    oi_d = tbl_tag[on1];
                end
            end
            default: state_d = S_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_ACCUM;
            n_q <= '0;
            p_q <= '0;
            o_q <= '0;
            busy_q <= 1'b0;
            ov_q <= 1'b0;
            oc_q <= 2'd0;
            oi_q <= '0;
            tag_q <= '0;
            new_tag_q <= '0;
            new_cls_q <= 2'd0;
            new_met_q <= '0;
        end else begin
            state_q <= state_d;
            n_q <= n_d;
            p_q <= p_d;
            o_q <= o_d;
            busy_q <= state_d != S_ACCUM;
            ov_q <= ov_d;
            oc_q <= oc_d;
            oi_q <= oi_d;
            if (acc && first) tag_q <= image_in_index;
            if (fin) begin
                new_tag_q <= tag_q;
                new_cls_q <= cls;
                new_met_q <= met;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (shift) begin
            tbl_cls[p_q] <= tbl_cls[pm1];
            tbl_met[p_q] <= tbl_met[pm1];
            tbl_tag[p_q] <= tbl_tag[pm1];
        end
        if (wr) begin
            tbl_cls[p_q] <= new_cls_q;
            tbl_met[p_q] <= new_met_q;
            tbl_tag[p_q] <= new_tag_q;
        end
    end

    assign busy = busy_q;
    assign out_valid = ov_q;
    assign color_index = oc_q;
    assign image_out_index = oi_q;
endmodule
